// File: rtl/cook_timer_ctrl_pkg.sv
// Shared types and constants for the microwave cook timer front panel.
// State encodings, BCD limits and the keypad digit width.
package cook_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int              KEY_W        = 4;
    localparam logic [KEY_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [KEY_W-1:0] SEC_TENS_MAX = 4'd5;

    function automatic logic is_bcd(input logic [KEY_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_entry_shift.sv
// Keypad entry register: DIGITS BCD digits, newest digit in the LSD.
// Ports: clk/rst, i_shift (key strobe), i_clear, i_digit -> o_digit_ok, o_entry.
module bcd_entry_shift
    import cook_timer_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_shift,
    input  logic                    i_clear,
    input  logic [KEY_W-1:0]        i_digit,
    output logic                    o_digit_ok,
    output logic [KEY_W*DIGITS-1:0] o_entry
);

    logic [KEY_W*DIGITS-1:0] r_entry;

    assign o_digit_ok = is_bcd(i_digit);
    assign o_entry    = r_entry;

    // Clear beats shift; the oldest digit falls off the MSD end.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_entry <= '0;
        end else if (i_shift && o_digit_ok) begin
            r_entry <= {r_entry[KEY_W*DIGITS-KEY_W-1:0], i_digit};
        end
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Cook timer sequencer: keypad entry, load/enable of the MM:SS counter chain,
// magnetron drive, door interlock, pause/cancel and end-of-cook beep.
// In: clock, clr, tick_1hz, key_valid/key_digit, start, stop, door_closed,
//     timer_zero. Out: load_data, timer_loadn, timer_clrn, timer_en,
//     mag_on, done_beep, busy.
module cook_timer_ctrl
    import cook_timer_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BEEP_SECS = 3
) (
    input  logic                    clock,
    input  logic                    clr,
    input  logic                    tick_1hz,
    input  logic                    key_valid,
    input  logic [KEY_W-1:0]        key_digit,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    door_closed,
    input  logic                    timer_zero,
    output logic [KEY_W*DIGITS-1:0] load_data,
    output logic                    timer_loadn,
    output logic                    timer_clrn,
    output logic                    timer_en,
    output logic                    mag_on,
    output logic                    done_beep,
    output logic                    busy
);

    localparam int            BW        = $clog2(BEEP_SECS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

    state_t r_state;
    state_t w_next;

    logic                    r_loadn;
    logic                    r_clrn;
    logic                    r_mag;
    logic                    r_beep;
    logic                    r_busy;
    logic                    r_first;
    logic [BW-1:0]           r_beep_cnt;

    logic                    w_shift;
    logic                    w_clear;
    logic                    w_clr_pulse;
    logic                    w_digit_ok;
    logic                    w_key_ok;
    logic                    w_start_ok;
    logic [KEY_W*DIGITS-1:0] w_entry;

    bcd_entry_shift #(
        .DIGITS(DIGITS)
    ) u_entry (
        .clk       (clock),
        .rst       (clr),
        .i_shift   (w_shift),
        .i_clear   (w_clear),
        .i_digit   (key_digit),
        .o_digit_ok(w_digit_ok),
        .o_entry   (w_entry)
    );

    assign w_key_ok   = key_valid && w_digit_ok;
    assign w_start_ok = start && door_closed && (w_entry != '0)
                        && (w_entry[7:4] <= SEC_TENS_MAX);

    // Combinational so the enable lines up with the tick itself.
    assign timer_en = (r_state == ST_COOK) && tick_1hz
                      && door_closed && !stop;

    always_comb begin
        w_next      = r_state;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        w_clr_pulse = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_shift = key_valid;
                if (w_key_ok) w_next = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (stop) begin
                    w_clear     = 1'b1;
                    w_clr_pulse = 1'b1;
                    w_next      = ST_IDLE;
                end else if (w_key_ok) begin
                    w_shift = 1'b1;
                end else if (w_start_ok) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: w_next = ST_COOK;
            ST_COOK: begin
                if (stop || !door_closed) begin
                    w_next = ST_PAUSE;
                end else if (timer_zero && !r_first) begin
                    // Zero flag is still settling on the first cycle.
                    w_next = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_clear     = 1'b1;
                    w_clr_pulse = 1'b1;
                    w_next      = ST_IDLE;
                end else if (start && door_closed) begin
                    w_next = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop || key_valid || start
                    || (tick_1hz && r_beep_cnt == BEEP_LAST)) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_loadn    <= 1'b1;
            r_clrn     <= 1'b0;
            r_mag      <= 1'b0;
            r_beep     <= 1'b0;
            r_busy     <= 1'b0;
            r_first    <= 1'b0;
            r_beep_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_loadn <= (w_next != ST_LOAD);
            r_clrn  <= !w_clr_pulse;
            r_mag   <= (w_next == ST_COOK);
            r_beep  <= (w_next == ST_DONE);
            r_busy  <= (w_next == ST_LOAD) || (w_next == ST_COOK)
                       || (w_next == ST_PAUSE);
            r_first <= (w_next == ST_COOK) && (r_state != ST_COOK);
            if (w_next == ST_DONE && r_state != ST_DONE) begin
                r_beep_cnt <= '0;
            end else if (r_state == ST_DONE && tick_1hz) begin
                r_beep_cnt <= r_beep_cnt + BW'(1);
            end
        end
    end

    assign load_data   = w_entry;
    assign timer_loadn = r_loadn;
    assign timer_clrn  = r_clrn;
    assign mag_on      = r_mag;
    assign done_beep   = r_beep;
    assign busy        = r_busy;

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
- Front-panel sequencer for the microwave cook timer: collects BCD keypad digits, loads them into the external MM:SS down-counter chain (cascaded mod10/mod6 counters), gates its 1 Hz enable and drives the magnetron.
- Handles door interlock, pause/resume, cancel and the end-of-cook beep.
- Sits between keypad/door/button debouncers and the timer counter chain; the counter chain stays a pure datapath.

Parameters:
- DIGITS, 4, number of BCD timer digits (M tens, M units, S tens, S units).
- BEEP_SECS, 3, number of tick_1hz periods done_beep stays high.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- tick_1hz  in  1  one-clock pulse per second.
- key_valid  in  1  one-clock pulse, key_digit valid.
- key_digit  in  4  BCD digit pressed.
- start  in  1  one-clock start/resume pulse.
- stop  in  1  one-clock stop/cancel pulse.
- door_closed  in  1  level, 1 = door closed.
- timer_zero  in  1  counter chain reports all digits zero.
- load_data  out  4*DIGITS  digits to load, MSD first.
- timer_loadn  out  1  active-low parallel load to counter chain.
- timer_clrn  out  1  active-low clear to counter chain.
- timer_en  out  1  count-down enable to counter chain.
- mag_on  out  1  magnetron drive.
- done_beep  out  1  end-of-cook buzzer.
- busy  out  1  high in LOAD, COOK, PAUSE.

Behaviour:
- Reset (clr=1 at edge): state IDLE, entry=0, load_data=0, timer_loadn=1, mag_on=0, done_beep=0, beep_cnt=0. timer_clrn=0 while clr is sampled high and for the first cycle after, then 1. Reset has priority over all inputs in every state, including mid-COOK.
- load_data always equals the entry register. Outputs are registered except timer_en.
- timer_en = (state==COOK) & tick_1hz & door_closed & !stop. This term is combinational so the enable aligns with the tick.
- States: IDLE, ENTRY, LOAD, COOK, PAUSE, DONE.
- Digit entry (IDLE or ENTRY): key_valid with key_digit<=9 shifts entry left one digit: entry={entry[4*DIGITS-5:0], key_digit}. The oldest digit drops off. key_digit>9 is ignored. IDLE->ENTRY on the first accepted digit.
- ENTRY, stop: entry=0, one-cycle timer_clrn=0, ->IDLE.
- ENTRY, start: accepted only if door_closed=1, entry!=0 and seconds-tens digit entry[7:4]<=5; then ->LOAD. Otherwise ignored and state held.
- ENTRY, simultaneous start+stop: stop wins. Simultaneous key_valid+start: digit shifted, start ignored that cycle.
- LOAD: exactly one cycle. timer_loadn=0 registered so the counter captures load_data on the next edge, then ->COOK.
- COOK: mag_on=1.
  - stop or !door_closed -> PAUSE; mag_on drops in the same registered cycle.
  - Else timer_zero=1 -> DONE. timer_zero is ignored on the first COOK cycle, because the counter's zero flag is still settling from the load.
  - Keys are ignored.
- PAUSE: mag_on=0, timer_en=0.
  - start with door_closed -> COOK; counting resumes from the held count.
  - stop -> IDLE, entry=0, one-cycle timer_clrn=0.
  - start while door open is ignored. Simultaneous start+stop: stop wins.
- DONE: mag_on=0, done_beep=1, beep_cnt counts tick_1hz pulses.
  - When beep_cnt reaches BEEP_SECS, or on stop/key_valid/start: done_beep=0, entry=0, ->IDLE.
  - Door opening does not cut the beep.
- busy=1 in LOAD, COOK, PAUSE.
- beep_cnt width is clog2(BEEP_SECS+1) and it is cleared on every DONE entry.

Decomposition:
- Shared package: state enum encodings (3 bits), BCD_MAX=9, SEC_TENS_MAX=5, and the keypad digit width constant.
- One natural sub-module, bcd_entry_shift: the DIGITS-wide BCD shift register with digit validation and clear. The FSM, output registers and beep counter stay in the top.

Test Plan:
- Enter 1,3,0 with door closed, then start -> load_data=16'h0130, timer_loadn low exactly 1 cycle, next cycle mag_on=1; timer_en pulses only coincident with tick_1hz.
- Model the counter reaching zero (timer_zero=1) in COOK -> mag_on=0 next cycle, done_beep=1 for 3 ticks, then IDLE with entry=0.
- Mid-COOK door_closed=0 -> PAUSE, mag_on=0, timer_en stays 0 through ticks; door closed then start -> COOK, counting continues from the held value.
- Enter 0,9,0 (seconds tens = 9) and press start -> stays ENTRY, no load pulse. Press start with door open and entry 16'h0030 -> ignored. Enter digit 4'hC -> entry unchanged.
- Enter 1,2,3,4,5 -> load_data=16'h2345 (oldest digit dropped). Start+stop in the same cycle -> IDLE, timer_clrn pulsed low for 1 cycle.
- Assert clr for one cycle mid-COOK -> next cycle IDLE, mag_on=0, done_beep=0, timer_clrn=0; entry digits accepted again after release.
